// File: rtl/lzd_decoder_pkg.sv
// Shared types and helpers for the LZD compress/expand datapath.
// The encoder side imports the same package for cnt_w().
package lzd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_MANT_W = 3;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/lzd_decoder_if.sv
// Request/result handshake bundle between the LZD decoder and its neighbours.
// master drives requests and takes results; slave is the decoder.
interface lzd_decoder_if
    import lzd_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int MANT_W = DEFAULT_MANT_W,
    parameter int CNT_W  = cnt_w(DEFAULT_WIDTH)
) ();

    logic              in_valid;
    logic              in_ready;
    logic [CNT_W-1:0]  in_count;
    logic [MANT_W-1:0] in_mant;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;

    modport master (
        output in_valid, in_count, in_mant, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_count, in_mant, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/lzd_decoder.sv
// Expands (leading-zero count, mantissa) back to a WIDTH-bit value by walking
// the MSB-aligned mantissa right one bit per cycle; truncated bits return as 0.
module lzd_decoder
    import lzd_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int MANT_W = DEFAULT_MANT_W
) (
    input logic         clk,
    input logic         rst,
    lzd_decoder_if.slave bus
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam int PAD_W = WIDTH - 1 - MANT_W;

    state_e            state_q;
    logic [WIDTH-1:0]  shift_q;
    logic [CNT_W-1:0]  remaining_q;

    logic              accept;
    logic [WIDTH-1:0]  loadValue;

    assign accept    = bus.in_valid && bus.in_ready;
    assign loadValue = WIDTH'({1'b1, bus.in_mant}) << PAD_W;

    // Counts of WIDTH or more all mean "the value was zero"; no shifting needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        remaining_q <= bus.in_count;
                        if (bus.in_count >= CNT_W'(WIDTH)) begin
                            shift_q <= '0;
                            state_q <= DONE;
                        end else begin
                            shift_q <= loadValue;
                            state_q <= (bus.in_count == '0) ? DONE : SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    shift_q     <= shift_q >> 1;
                    remaining_q <= remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = !rst && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = shift_q;

endmodule

// File: tb/tb_lzd_decoder.sv
// Directed and randomized checks of lzd_decoder against a value-level model
// of the LZD compression (count + kept mantissa bits).
module tb_lzd_decoder;
    import lzd_pkg::*;

    localparam int W  = 8;
    localparam int M  = 3;
    localparam int CW = cnt_w(W);

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lzd_decoder_if #(.WIDTH(W), .MANT_W(M), .CNT_W(CW)) bus ();

    lzd_decoder #(.WIDTH(W), .MANT_W(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents one request, returns just after the accept edge.
    task automatic applyStimulus(input int count, input int mant);
        int waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        checkOutput("in_ready_before_accept", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_count = CW'(count);
        bus.in_mant  = M'(mant);
        tick();
        bus.in_valid = 1'b0;
        bus.in_count = CW'($urandom);
        bus.in_mant  = M'($urandom);
    endtask

    // Counts edges after the accept until out_valid, checks data, then takes the result.
    task automatic collectResult(input string tag, input int expData, input int expLat);
        int lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, expLat);
        checkOutput({tag, "_data"}, int'(bus.out_data), expData);
        checkOutput({tag, "_in_ready_done"}, int'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput({tag, "_out_valid_after"}, int'(bus.out_valid), 0);
        checkOutput({tag, "_in_ready_after"}, int'(bus.in_ready), 1);
    endtask

    // Compresses x the way the encoder does and predicts the expanded value.
    task automatic refModel(input int x, output int cnt, output int mant, output int expData);
        int p;
        if (x == 0) begin
            cnt     = W;
            mant    = $urandom_range(0, (1 << M) - 1);
            expData = 0;
        end else begin
            p = W - 1;
            while (x < (1 << p)) p--;
            cnt     = W - 1 - p;
            mant    = ((x << M) >> p) % (1 << M);
            expData = (p > M) ? x - (x % (1 << (p - M))) : x;
        end
    endtask

    initial begin
        int cnt, mant, expData, x, seenValid;

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_count  = CW'(3);
        bus.in_mant   = M'(3'b011);
        bus.out_ready = 1'b0;
        tick();
        checkOutput("in_ready_during_reset", int'(bus.in_ready), 0);
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checkOutput("reset_in_ready", int'(bus.in_ready), 1);
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_out_data", int'(bus.out_data), 0);

        applyStimulus(3, 3'b011);
        collectResult("c3_m011", 8'h16, 3);
        applyStimulus(0, 3'b101);
        collectResult("c0_m101", 8'hD0, 0);
        applyStimulus(5, 3'b111);
        collectResult("c5_m111", 8'h07, 5);
        applyStimulus(7, 3'b111);
        collectResult("c7_m111", 8'h01, 7);
        applyStimulus(8, 3'b101);
        collectResult("c8_zero", 8'h00, 0);
        applyStimulus(12, 3'b111);
        collectResult("c12_sat", 8'h00, 0);

        // Backpressure: result must hold while requests are offered and refused.
        applyStimulus(4, 3'b110);
        seenValid = 0;
        while (bus.out_valid !== 1'b1 && seenValid < 40) begin
            tick();
            seenValid++;
        end
        checkOutput("bp_latency", seenValid, 4);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_count = CW'(0);
            bus.in_mant  = M'(0);
            tick();
            checkOutput("bp_out_valid", int'(bus.out_valid), 1);
            checkOutput("bp_out_data", int'(bus.out_data), 8'h0E);
            checkOutput("bp_in_ready", int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("bp_release_out_valid", int'(bus.out_valid), 0);
        checkOutput("bp_release_in_ready", int'(bus.in_ready), 1);
        checkOutput("bp_release_data_held", int'(bus.out_data), 8'h0E);

        // Reset lands mid-shift; the pending result must vanish.
        applyStimulus(6, 3'b100);
        tick();
        tick();
        checkOutput("rst_mid_not_done", int'(bus.out_valid), 0);
        rst = 1'b1;
        tick();
        checkOutput("rst_mid_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_mid_out_data", int'(bus.out_data), 0);
        checkOutput("rst_mid_in_ready", int'(bus.in_ready), 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_idle", int'(bus.in_ready), 1);
        seenValid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seenValid = 1;
        end
        checkOutput("rst_mid_no_result", seenValid, 0);
        applyStimulus(2, 3'b010);
        collectResult("after_rst", 8'h28, 2);

        for (int i = 0; i < 40; i++) begin
            x = (i == 0) ? 0 : int'($urandom_range(0, 255));
            refModel(x, cnt, mant, expData);
            applyStimulus(cnt, mant);
            collectResult($sformatf("rand_x%02h", x), expData, (cnt < W) ? cnt : 0);
        end

        $display("[TB] sweep complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
